// File: rtl/bit_stream_deserializer.sv
// Serial-to-parallel deserializer with a one-entry valid/ready output register and sticky overrun.
// Optional even-parity frame bit enabled by defining BIT_DESER_PARITY_EN (adds out_perr).
module bit_stream_deserializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             overrun_clr,
`ifdef BIT_DESER_PARITY_EN
  output logic             out_perr,
`endif
  output logic             busy
);

`ifdef BIT_DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt;
  logic             shift_en;
  logic             last;
  logic             drain;
  logic             load;
  logic             drop;
`ifdef BIT_DESER_PARITY_EN
  logic             perr;
`endif

  always_comb begin
    sr_next = sr;
    if (MSB_FIRST != 0) begin
      sr_next = {sr[WIDTH-2:0], in_bit};
    end else begin
      sr_next = {in_bit, sr[WIDTH-1:1]};
    end
    last  = in_valid && (cnt == LAST);
    drain = out_valid && out_ready;
    load  = last && (!out_valid || out_ready);
    drop  = last && out_valid && !out_ready;
`ifdef BIT_DESER_PARITY_EN
    // Final frame bit is parity: data is already complete in sr and the bit is not shifted in.
    shift_en = in_valid && (cnt != LAST);
    word     = sr;
    perr     = (^sr) ^ in_bit;
`else
    shift_en = in_valid;
    word     = sr_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr        <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
`ifdef BIT_DESER_PARITY_EN
      out_perr  <= 1'b0;
`endif
    end else begin
      if (shift_en) begin
        sr <= sr_next;
      end
      if (in_valid) begin
        cnt <= last ? '0 : cnt + CW'(1);
      end
      if (load) begin
        out_data  <= word;
        out_valid <= 1'b1;
`ifdef BIT_DESER_PARITY_EN
        out_perr  <= perr;
`endif
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: tb/tb_bit_stream_deserializer.sv
// Directed self-checking bench for bit_stream_deserializer (MSB-first and LSB-first instances).
module tb_bit_stream_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [7:0] m_data, l_data;
  logic       m_valid, l_valid, m_ovr, l_ovr, m_busy, l_busy;
`ifdef BIT_DESER_PARITY_EN
  logic       m_perr, l_perr;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bit_stream_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
    .overrun(m_ovr), .overrun_clr(overrun_clr),
`ifdef BIT_DESER_PARITY_EN
    .out_perr(m_perr),
`endif
    .busy(m_busy)
  );

  bit_stream_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
    .overrun(l_ovr), .overrun_clr(overrun_clr),
`ifdef BIT_DESER_PARITY_EN
    .out_perr(l_perr),
`endif
    .busy(l_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    in_bit   = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Bits go out in order w[7] .. w[0]; a correct even-parity bit follows when parity is built in.
  task automatic send_word(input logic [7:0] w, input int gap);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      repeat (gap) tick();
    end
`ifdef BIT_DESER_PARITY_EN
    send_bit(^w);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    overrun_clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({m_data, m_valid, m_ovr, m_busy} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_msb: got data=%h valid=%b ovr=%b busy=%b, need all 0", m_data, m_valid, m_ovr, m_busy);
    end
    tests_run++;
    if ({l_data, l_valid, l_ovr, l_busy} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_lsb: got data=%h valid=%b ovr=%b busy=%b, need all 0", l_data, l_valid, l_ovr, l_busy);
    end
`ifdef BIT_DESER_PARITY_EN
    tests_run++;
    if (m_perr !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_perr: got %b need 0", m_perr);
    end
`endif
  endtask

  task automatic test_msb_first();
    logic [7:0] w;
    do_reset();
    out_ready = 1'b1;
    w = 8'hC0;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
`ifdef BIT_DESER_PARITY_EN
    send_bit(w[0]);
`endif
    tests_run++;
    if (m_busy !== 1'b1 || m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL msb_partial: got busy=%b valid=%b, need busy=1 valid=0", m_busy, m_valid);
    end
`ifdef BIT_DESER_PARITY_EN
    send_bit(^w);
`else
    send_bit(w[0]);
`endif
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== 8'hC0 || m_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL msb_word: got valid=%b data=%h busy=%b, need 1 c0 0", m_valid, m_data, m_busy);
    end
    tests_run++;
    if (l_valid !== 1'b1 || l_data !== 8'h03) begin
      tests_failed++;
      $display("FAIL lsb_word: got valid=%b data=%h, need 1 03", l_valid, l_data);
    end
    tick();
    tests_run++;
    if (m_valid !== 1'b0 || m_data !== 8'hC0) begin
      tests_failed++;
      $display("FAIL msb_one_cycle: got valid=%b data=%h, need 0 c0", m_valid, m_data);
    end
  endtask

  task automatic test_lsb_gaps();
    do_reset();
    out_ready = 1'b1;
    send_word(8'hC0, 3);
    // The trailing gap after the last bit lets the word be consumed; check during it instead.
    do_reset();
    out_ready = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      send_bit(i >= 6);
      repeat (3) tick();
    end
`ifdef BIT_DESER_PARITY_EN
    send_bit(1'b0);
    repeat (3) tick();
    send_bit(1'b0);
`else
    send_bit(1'b0);
`endif
    tests_run++;
    if (l_valid !== 1'b1 || l_data !== 8'h03) begin
      tests_failed++;
      $display("FAIL lsb_gaps: got valid=%b data=%h, need 1 03", l_valid, l_data);
    end
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== 8'hC0) begin
      tests_failed++;
      $display("FAIL msb_gaps: got valid=%b data=%h, need 1 c0", m_valid, m_data);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    send_word(8'hA5, 0);
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_ovr !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovr_first: got valid=%b data=%h ovr=%b, need 1 a5 0", m_valid, m_data, m_ovr);
    end
    send_word(8'h3C, 0);
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_ovr !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovr_drop: got valid=%b data=%h ovr=%b, need 1 a5 1", m_valid, m_data, m_ovr);
    end
    out_ready = 1'b1;
    tick();
    tick();
    tests_run++;
    if (m_valid !== 1'b0 || m_data !== 8'hA5 || m_ovr !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovr_drain: got valid=%b data=%h ovr=%b, need 0 a5 1", m_valid, m_data, m_ovr);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    tests_run++;
    if (m_ovr !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovr_clr: got %b need 0", m_ovr);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    do_reset();
    send_word(8'h11, 0);
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== 8'h11) begin
      tests_failed++;
      $display("FAIL b2b_first: got valid=%b data=%h, need 1 11", m_valid, m_data);
    end
    w = 8'h22;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
`ifdef BIT_DESER_PARITY_EN
    send_bit(w[0]);
    out_ready = 1'b1;
    send_bit(^w);
`else
    out_ready = 1'b1;
    send_bit(w[0]);
`endif
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== 8'h22 || m_ovr !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second: got valid=%b data=%h ovr=%b, need 1 22 0", m_valid, m_data, m_ovr);
    end
    tick();
    tests_run++;
    if (m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_drain: got valid=%b need 0", m_valid);
    end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    out_ready = 1'b1;
    repeat (5) send_bit(1'b1);
    tests_run++;
    if (m_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_busy: got %b need 1", m_busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests_run++;
    if (m_busy !== 1'b0 || m_valid !== 1'b0 || m_ovr !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: got busy=%b valid=%b ovr=%b, need 0 0 0", m_busy, m_valid, m_ovr);
    end
    repeat (7) send_bit(1'b1);
    tests_run++;
    if (m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_early: got valid=%b need 0", m_valid);
    end
`ifdef BIT_DESER_PARITY_EN
    send_bit(1'b1);
    send_bit(1'b0);
`else
    send_bit(1'b1);
`endif
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== 8'hFF) begin
      tests_failed++;
      $display("FAIL mid_word: got valid=%b data=%h, need 1 ff", m_valid, m_data);
    end
    tick();
    tests_run++;
    if (m_valid !== 1'b0 || m_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_single: got valid=%b busy=%b, need 0 0", m_valid, m_busy);
    end
  endtask

`ifdef BIT_DESER_PARITY_EN
  task automatic test_parity();
    logic [7:0] w;
    do_reset();
    w = 8'h07;
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
    send_bit(1'b1);
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== 8'h07 || m_perr !== 1'b0) begin
      tests_failed++;
      $display("FAIL par_good: got valid=%b data=%h perr=%b, need 1 07 0", m_valid, m_data, m_perr);
    end
    out_ready = 1'b1;
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
    send_bit(1'b0);
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== 8'h07 || m_perr !== 1'b1 || m_ovr !== 1'b0) begin
      tests_failed++;
      $display("FAIL par_bad: got valid=%b data=%h perr=%b ovr=%b, need 1 07 1 0", m_valid, m_data, m_perr, m_ovr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_gaps();
    test_overrun();
    test_back_to_back();
    test_reset_mid_word();
`ifdef BIT_DESER_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
